// File: rtl/pipeline_wb_ext_pkg.sv
// Shared encodings for the write-back stage: result-source and load funct3 codes.
package pipeline_wb_ext_pkg;

    localparam int unsigned RIDX_W = 5;
    localparam int unsigned SRC_W  = 2;
    localparam int unsigned LT_W   = 3;

    typedef enum logic [SRC_W-1:0] {
        WBSRC_ALU = 2'b00,
        WBSRC_MEM = 2'b01,
        WBSRC_PC  = 2'b10,
        WBSRC_IMM = 2'b11
    } wb_src_e;

    typedef enum logic [LT_W-1:0] {
        LOAD_LB  = 3'b000,
        LOAD_LH  = 3'b001,
        LOAD_LW  = 3'b010,
        LOAD_LD  = 3'b011,
        LOAD_LBU = 3'b100,
        LOAD_LHU = 3'b101,
        LOAD_LWU = 3'b110
    } load_type_e;

    // Only 32- and 64-bit datapaths are supported.
    function automatic bit xlen_legal(input int unsigned xlen);
        return (xlen == 32) || (xlen == 64);
    endfunction

endpackage

// File: rtl/pipeline_wb_ext_load_extract.sv
// Combinational load lane selection, sign/zero extension and misalignment detection.
module pipeline_wb_ext_load_extract
    import pipeline_wb_ext_pkg::*;
#(
    parameter  int unsigned XLEN  = 32,
    localparam int unsigned OFS_W = $clog2(XLEN/8)
) (
    input  logic [XLEN-1:0]  raw_word,
    input  logic [LT_W-1:0]  load_type,
    input  logic [OFS_W-1:0] ofs,
    output logic [XLEN-1:0]  ext_data,
    output logic             misaligned
);

    load_type_e      lt;
    logic [XLEN-1:0] lane;
    logic [7:0]      lane_b;
    logic [15:0]     lane_h;
    logic [31:0]     lane_w;
    logic            mis_half;
    logic            mis_word;
    logic            mis_full;

    assign lt = load_type_e'(load_type);

    // Little-endian: shift the addressed byte down to lane 0.
    always_comb begin
        lane     = raw_word >> {ofs, 3'b000};
        lane_b   = lane[7:0];
        lane_h   = lane[15:0];
        lane_w   = lane[31:0];
        mis_half = ofs[0];
        mis_word = |ofs[1:0];
        mis_full = |ofs;
    end

    // LD on a 32-bit datapath degenerates to LW: lane is the full word and mis_full covers ofs[1:0].
    always_comb begin
        ext_data   = raw_word;
        misaligned = 1'b0;
        case (lt)
            LOAD_LB:  ext_data = XLEN'($signed(lane_b));
            LOAD_LBU: ext_data = XLEN'(lane_b);
            LOAD_LH: begin
                ext_data   = XLEN'($signed(lane_h));
                misaligned = mis_half;
            end
            LOAD_LHU: begin
                ext_data   = XLEN'(lane_h);
                misaligned = mis_half;
            end
            LOAD_LW: begin
                ext_data   = XLEN'($signed(lane_w));
                misaligned = mis_word;
            end
            LOAD_LWU: begin
                ext_data   = XLEN'(lane_w);
                misaligned = mis_word;
            end
            LOAD_LD: begin
                ext_data   = lane;
                misaligned = mis_full;
            end
            default: begin
                ext_data   = raw_word;
                misaligned = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/pipeline_wb_ext.sv
// Write-back stage: result mux, load extension, stall/flush priority and retire counter.
module pipeline_wb_ext
    import pipeline_wb_ext_pkg::*;
#(
    parameter  int unsigned XLEN  = 32,
    parameter  int unsigned CNT_W = 64,
    localparam int unsigned OFS_W = $clog2(XLEN/8)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              validM_i,
    input  logic [XLEN-1:0]   aluResultM_i,
    input  logic [XLEN-1:0]   memReadDataM_i,
    input  logic [XLEN-1:0]   extendedImmM_i,
    input  logic [XLEN-1:0]   pcPlus4M_i,
    input  logic              regWriteEnM_i,
    input  logic [RIDX_W-1:0] rdIdxM_i,
    input  logic [SRC_W-1:0]  resultSrcM_i,
    input  logic [LT_W-1:0]   loadTypeM_i,
    input  logic [OFS_W-1:0]  memOfsM_i,
    output logic              regWriteEnW_o,
    output logic [RIDX_W-1:0] rdIdxW_o,
    output logic [XLEN-1:0]   writeBackDataW_o,
    output logic              validW_o,
    output logic              misalignW_o,
    output logic [CNT_W-1:0]  retireCntW_o
);

    if (!xlen_legal(XLEN)) begin : g_bad_xlen
        $error("pipeline_wb_ext: XLEN must be 32 or 64");
    end

    wb_src_e         src;
    logic [XLEN-1:0] load_data;
    logic            load_mis;
    logic [XLEN-1:0] wb_data;
    logic            mis;
    logic            wr_en;
    logic            retire;

    assign src = wb_src_e'(resultSrcM_i);

    pipeline_wb_ext_load_extract #(
        .XLEN (XLEN)
    ) u_load_extract (
        .raw_word   (memReadDataM_i),
        .load_type  (loadTypeM_i),
        .ofs        (memOfsM_i),
        .ext_data   (load_data),
        .misaligned (load_mis)
    );

    // Result mux plus the write-enable / retire qualification for the MEM-stage instruction.
    always_comb begin
        wb_data = aluResultM_i;
        case (src)
            WBSRC_ALU: wb_data = aluResultM_i;
            WBSRC_MEM: wb_data = load_data;
            WBSRC_PC:  wb_data = pcPlus4M_i;
            WBSRC_IMM: wb_data = extendedImmM_i;
            default:   wb_data = aluResultM_i;
        endcase
        mis    = validM_i & (src == WBSRC_MEM) & load_mis;
        wr_en  = validM_i & regWriteEnM_i & (rdIdxM_i != '0) & ~mis;
        retire = validM_i & ~mis;
    end

    // Priority: reset > flush > stall > capture. A stall clears the misalign pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            regWriteEnW_o    <= 1'b0;
            rdIdxW_o         <= '0;
            writeBackDataW_o <= '0;
            validW_o         <= 1'b0;
            misalignW_o      <= 1'b0;
            retireCntW_o     <= '0;
        end else if (flush_i) begin
            regWriteEnW_o    <= 1'b0;
            rdIdxW_o         <= '0;
            writeBackDataW_o <= '0;
            validW_o         <= 1'b0;
            misalignW_o      <= 1'b0;
        end else if (stall_i) begin
            misalignW_o      <= 1'b0;
        end else begin
            regWriteEnW_o    <= wr_en;
            rdIdxW_o         <= rdIdxM_i;
            writeBackDataW_o <= wb_data;
            validW_o         <= validM_i;
            misalignW_o      <= mis;
            if (retire) begin
                retireCntW_o <= retireCntW_o + CNT_W'(1);
            end
        end
    end

endmodule

// File: doc/pipeline_wb_ext.md
Name: pipeline_wb_ext

Overview:
Parametrised next-generation write-back stage of the 5-stage pipeline. Registers one of four result sources into the register-file write port, like the existing WB stage. Adds:
- width generality: XLEN 32 or 64
- load byte/halfword/word extraction with sign/zero extension
- misaligned-load detection
- stall/flush control
- a valid bit
- a retired-instruction counter

It sits between the MEM stage and the register file in ID, and feeds the hazard and forwarding logic.

Parameters:
XLEN, 32, datapath width; only 32 or 64 are legal.
CNT_W, 64, width of the retired-instruction counter.
OFS_W, derived as log2(XLEN/8), width of the load address byte-offset input.

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
stall_i  in  1  hold all WB registers
flush_i  in  1  insert a bubble; has priority over stall_i
validM_i  in  1  MEM-stage instruction is valid
aluResultM_i  in  XLEN  ALU result
memReadDataM_i  in  XLEN  raw, aligned D-memory read word
extendedImmM_i  in  XLEN  immediate (lui)
pcPlus4M_i  in  XLEN  pc+4 (jal/jalr)
regWriteEnM_i  in  1  RF write request
rdIdxM_i  in  5  destination register index
resultSrcM_i  in  2  WBSRC_ALU/IMM/MEM/PC
loadTypeM_i  in  3  funct3 load code: LB/LH/LW/LD/LBU/LHU/LWU
memOfsM_i  in  OFS_W  low address bits of the load
regWriteEnW_o  out  1  RF write enable
rdIdxW_o  out  5  RF write index
writeBackDataW_o  out  XLEN  RF write data
validW_o  out  1  WB holds a retired instruction
misalignW_o  out  1  1-cycle flag: the last captured load was misaligned
retireCntW_o  out  CNT_W  retired-instruction count

Behaviour:
- All outputs are registered. Latency from MEM inputs to WB outputs is exactly 1 cycle.
- Reset (reset=1 at a clk edge): every output is 0, including retireCntW_o. Reset overrides flush_i and stall_i. Reset mid-stall discards the held state.
- Update priority at each edge: reset > flush_i > stall_i > capture.
- flush_i:
  - validW_o, regWriteEnW_o, misalignW_o and rdIdxW_o go to 0; writeBackDataW_o goes to 0.
  - Counter unchanged.
- stall_i (no flush): all outputs hold their values, except misalignW_o, which goes to 0 so the flag is never repeated.
- Capture:
  - validW_o = validM_i.
  - rdIdxW_o = rdIdxM_i.
  - mis = validM_i & resultSrcM_i==WBSRC_MEM & misaligned(loadType, ofs).
  - regWriteEnW_o = validM_i & regWriteEnM_i & (rdIdxM_i!=0) & ~mis.
  - misalignW_o = mis.
  - retireCntW_o increments by 1 when validM_i & ~mis. It wraps modulo 2^CNT_W.
- Data mux:
  - ALU gives aluResultM_i.
  - IMM gives extendedImmM_i.
  - PC gives pcPlus4M_i.
  - MEM gives the extracted load.
  - An undefined code selects ALU.
- Load extraction: select the byte/half/word lane at byte offset memOfsM_i (little-endian), then extend to XLEN.
  - LB, LH and LW sign-extend.
  - LBU, LHU and LWU zero-extend.
  - LD passes the full 64-bit word.
- Misalignment rules:
  - LH/LHU with ofs[0]≠0.
  - LW/LWU with ofs[1:0]≠0.
  - LD with ofs[2:0]≠0.
  - Byte loads are never misaligned.
- XLEN=32:
  - LD and LWU are treated as LW.
  - An unknown loadType passes the raw word unchanged, with no misalignment.
- Data written on a misaligned load is don't-care, but the enable is guaranteed 0.

Decomposition:
- definitions.vh:
  - add LOAD_LB..LOAD_LWU funct3 codes next to the existing WBSRC_* codes.
  - add the XLEN legality check macro.
- One combinational sub-module, load_extract:
  - inputs: raw word, loadType, offset.
  - outputs: extended value, misaligned flag.
- The top level keeps the pipeline register, the priority logic and the counter.

Test Plan:
- Reset: hold reset=1 for 2 cycles with random inputs → all outputs 0. Then capture ALU 0x0000_1234 to rd=5 → next cycle regWriteEnW_o=1, rdIdxW_o=5, data=0x1234, retireCntW_o=1.
- Loads (XLEN=32), mem word 0x80FF_7F01:
  - LB, ofs=3 → 0xFFFF_FF80.
  - LBU, ofs=3 → 0x0000_0080.
  - LH, ofs=2 → 0xFFFF_80FF.
  - LHU, ofs=0 → 0x0000_7F01.
  - LW, ofs=0 → 0x80FF_7F01.
- Misalignment: LW with ofs=2, regWriteEnM_i=1 → regWriteEnW_o=0, misalignW_o=1 for exactly 1 cycle, counter not incremented.
- rd=0 write: regWriteEnM_i=1, rdIdxM_i=0 → regWriteEnW_o=0, validW_o=1, counter +1.
- Stall/flush:
  - Capture PC 0x100 to rd=1, then stall 3 cycles while inputs change → outputs constant.
  - Then flush_i=1 together with stall_i=1 → validW_o=0, regWriteEnW_o=0, counter unchanged.
- Counter wrap: with CNT_W=4, retire 17 valid instructions → retireCntW_o=1.
